// File: rtl/fpga_cfg_loader.sv
// Byte-stream configuration loader: framed (sync, id, payload, xor checksum)
// writes into a shadow buffer, committed atomically to one of seven targets.
module fpga_cfg_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   cfg_data,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  output logic [143:0] LUT_in,
  output logic [239:0] SB_in,
  output logic [419:0] CB_in,
  output logic [35:0]  sel_direction_BLEout,
  output logic [17:0]  sel_direction,
  output logic [8:0]   BLE_dff_select,
  output logic [3:0]   IO_sel,
  output logic         cfg_done,
  output logic         cfg_err,
  output logic         cfg_complete
);

  localparam int NUM_LANES = 53;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ID      = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_id;
  logic [5:0]       r_cnt;
  logic [7:0]       r_xor;
  logic [419:0]     r_shadow;
  logic [6:0]       r_mask;
  logic             w_xfer;
  logic             w_pay_wr;
  logic             w_commit;
  logic             w_err_next;
  logic [5:0]       w_last_idx;
  logic [NUM_LANES-1:0] w_lane_we;

  assign cfg_ready = !reset && (r_state != S_COMMIT);
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_pay_wr  = w_xfer && (r_state == S_PAYLOAD);

  // Index of the final payload byte for the latched target.
  always_comb begin
    w_last_idx = 6'd0;
    case (r_id)
      3'd0:    w_last_idx = 6'd17;
      3'd1:    w_last_idx = 6'd29;
      3'd2:    w_last_idx = 6'd52;
      3'd3:    w_last_idx = 6'd4;
      3'd4:    w_last_idx = 6'd2;
      3'd5:    w_last_idx = 6'd1;
      default: w_last_idx = 6'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && (cfg_data == SYNC_BYTE)) w_state_next = S_ID;
      end
      S_ID: begin
        if (w_xfer) begin
          if (cfg_data <= 8'd6) begin
            w_state_next = S_PAYLOAD;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_xfer && (r_cnt == w_last_idx)) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_xfer) begin
          if (cfg_data == r_xor) begin
            w_state_next = S_COMMIT;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        w_commit     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_lane_we[gi] = w_pay_wr && (r_cnt == 6'(gi));
    end
  endgenerate

  // The final CB byte only has four destination bits; its upper nibble is dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES - 1; i++) begin
      if (w_lane_we[i]) r_shadow[i*8 +: 8] <= cfg_data;
    end
    if (w_lane_we[NUM_LANES-1]) r_shadow[419:416] <= cfg_data[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id                 <= 3'd0;
      r_cnt                <= 6'd0;
      r_xor                <= 8'd0;
      r_mask               <= 7'd0;
      LUT_in               <= '0;
      SB_in                <= '0;
      CB_in                <= '0;
      sel_direction_BLEout <= '0;
      sel_direction        <= '0;
      BLE_dff_select       <= '0;
      IO_sel               <= '0;
      cfg_done             <= 1'b0;
      cfg_err              <= 1'b0;
      cfg_complete         <= 1'b0;
    end else begin
      cfg_done     <= w_commit;
      cfg_err      <= w_err_next;
      cfg_complete <= &r_mask;

      if ((r_state == S_ID) && w_xfer && (cfg_data <= 8'd6)) begin
        r_id  <= cfg_data[2:0];
        r_cnt <= 6'd0;
        r_xor <= cfg_data;
      end

      if (w_pay_wr) begin
        r_xor <= r_xor ^ cfg_data;
        r_cnt <= r_cnt + 6'd1;
      end

      if (w_commit) begin
        case (r_id)
          3'd0: begin LUT_in               <= r_shadow[143:0]; r_mask[0] <= 1'b1; end
          3'd1: begin SB_in                <= r_shadow[239:0]; r_mask[1] <= 1'b1; end
          3'd2: begin CB_in                <= r_shadow[419:0]; r_mask[2] <= 1'b1; end
          3'd3: begin sel_direction_BLEout <= r_shadow[35:0];  r_mask[3] <= 1'b1; end
          3'd4: begin sel_direction        <= r_shadow[17:0];  r_mask[4] <= 1'b1; end
          3'd5: begin BLE_dff_select       <= r_shadow[8:0];   r_mask[5] <= 1'b1; end
          3'd6: begin IO_sel               <= r_shadow[3:0];   r_mask[6] <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Randomised frame stimulus with a scoreboard of expected done/err events,
// checked by an independent monitor against a frame-level reference model.
module tb_fpga_cfg_loader;

  logic         clk;
  logic         reset;
  logic [7:0]   cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [143:0] LUT_in;
  logic [239:0] SB_in;
  logic [419:0] CB_in;
  logic [35:0]  sel_direction_BLEout;
  logic [17:0]  sel_direction;
  logic [8:0]   BLE_dff_select;
  logic [3:0]   IO_sel;
  logic         cfg_done;
  logic         cfg_err;
  logic         cfg_complete;

  fpga_cfg_loader #(.SYNC_BYTE(8'hA5)) dut (
    .clk                  (clk),
    .reset                (reset),
    .cfg_data             (cfg_data),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .LUT_in               (LUT_in),
    .SB_in                (SB_in),
    .CB_in                (CB_in),
    .sel_direction_BLEout (sel_direction_BLEout),
    .sel_direction        (sel_direction),
    .BLE_dff_select       (BLE_dff_select),
    .IO_sel               (IO_sel),
    .cfg_done             (cfg_done),
    .cfg_err              (cfg_err),
    .cfg_complete         (cfg_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_done;
    logic [7:0]   id;
    logic [143:0] lut;
    logic [239:0] sb;
    logic [419:0] cb;
    logic [35:0]  dirb;
    logic [17:0]  dir;
    logic [8:0]   ble;
    logic [3:0]   io;
    logic         cmp_now;
    logic         cmp_next;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  bit g_stall = 1'b0;

  logic [7:0]   pl [53];
  logic [143:0] m_lut;
  logic [239:0] m_sb;
  logic [419:0] m_cb;
  logic [35:0]  m_dirb;
  logic [17:0]  m_dir;
  logic [8:0]   m_ble;
  logic [3:0]   m_io;
  logic [6:0]   m_mask;

  task automatic chk(input string name, input logic [423:0] act, input logic [423:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int n_of(input logic [7:0] id);
    case (id)
      8'd0: return 18;
      8'd1: return 30;
      8'd2: return 53;
      8'd3: return 5;
      8'd4: return 3;
      8'd5: return 2;
      8'd6: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    m_lut = '0; m_sb = '0; m_cb = '0; m_dirb = '0;
    m_dir = '0; m_ble = '0; m_io = '0; m_mask = '0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_lut"},  424'(LUT_in),               424'(m_lut));
    chk({tag, "_sb"},   424'(SB_in),                424'(m_sb));
    chk({tag, "_cb"},   424'(CB_in),                424'(m_cb));
    chk({tag, "_dirb"}, 424'(sel_direction_BLEout), 424'(m_dirb));
    chk({tag, "_dir"},  424'(sel_direction),        424'(m_dir));
    chk({tag, "_ble"},  424'(BLE_dff_select),       424'(m_ble));
    chk({tag, "_io"},   424'(IO_sel),               424'(m_io));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int stall;
    int guard;
    stall = g_stall ? int'($urandom_range(0, 3)) : 0;
    repeat (stall) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_data  = 8'($urandom);
    end
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = b;
    guard = 0;
    while (!cfg_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (!cfg_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got cfg_ready=0 want 1 within 16 cycles");
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) pl[k] = 8'($urandom);
  endtask

  // Sends one frame using pl[0..n-1]; records the expected event unless the
  // frame is going to be killed by a reset during its commit cycle.
  task automatic send_frame(input logic [7:0] id, input bit corrupt, input bit rst_in_commit);
    int n;
    logic [7:0]   x;
    logic [7:0]   cs;
    logic [423:0] p;
    bit good;
    exp_t e;
    n = n_of(id);
    x = id;
    for (int k = 0; k < n; k++) x = x ^ pl[k];
    cs = corrupt ? (x ^ 8'($urandom_range(1, 255))) : x;
    good = (id <= 8'd6) && !corrupt;
    if (!rst_in_commit) begin
      e = '0;
      e.id = id;
      if (good) begin
        p = '0;
        for (int k = 0; k < n; k++) p[k*8 +: 8] = pl[k];
        e.cmp_now = &m_mask;
        case (id)
          8'd0: begin m_lut  = p[143:0]; m_mask[0] = 1'b1; end
          8'd1: begin m_sb   = p[239:0]; m_mask[1] = 1'b1; end
          8'd2: begin m_cb   = p[419:0]; m_mask[2] = 1'b1; end
          8'd3: begin m_dirb = p[35:0];  m_mask[3] = 1'b1; end
          8'd4: begin m_dir  = p[17:0];  m_mask[4] = 1'b1; end
          8'd5: begin m_ble  = p[8:0];   m_mask[5] = 1'b1; end
          default: begin m_io = p[3:0];  m_mask[6] = 1'b1; end
        endcase
        e.is_done  = 1'b1;
        e.cmp_next = &m_mask;
        e.lut = m_lut; e.sb = m_sb; e.cb = m_cb; e.dirb = m_dirb;
        e.dir = m_dir; e.ble = m_ble; e.io = m_io;
      end
      q.push_back(e);
    end
    send_byte(8'hA5);
    send_byte(id);
    if (id > 8'd6) return;
    for (int k = 0; k < n; k++) send_byte(pl[k]);
    send_byte(cs);
    if (good) begin
      chk("ready_low_commit", 424'(cfg_ready), 424'(1'b0));
      if (rst_in_commit) begin
        reset = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      chk("ready_high_after_commit", 424'(cfg_ready), 424'(1'b1));
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending events want 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    chk_all("reset");
    chk("reset_ready",    424'(cfg_ready),    424'(1'b0));
    chk("reset_done",     424'(cfg_done),     424'(1'b0));
    chk("reset_err",      424'(cfg_err),      424'(1'b0));
    chk("reset_complete", 424'(cfg_complete), 424'(1'b0));
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 424'(cfg_ready), 424'(1'b1));
  endtask

  // Monitor: every done/err pulse must match the next expected event.
  initial begin
    exp_t e;
    bit pend_next;
    logic want_next;
    pend_next = 1'b0;
    want_next = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_next) begin
        chk("complete_next", 424'(cfg_complete), 424'(want_next));
        pend_next = 1'b0;
      end
      if (cfg_done === 1'b1 || cfg_err === 1'b1) begin
        if (cfg_done === 1'b1 && cfg_err === 1'b1) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_err_exclusive: got done=1 err=1 want at most one");
        end else if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got done=%0b err=%0b want no event", cfg_done, cfg_err);
        end else begin
          e = q.pop_front();
          n_txn++;
          $display("txn %0d: id=%0d %s", n_txn, e.id, e.is_done ? "commit" : "reject");
          chk("event_kind", 424'(cfg_done), 424'(e.is_done));
          if (e.is_done) begin
            chk("ev_lut",  424'(LUT_in),               424'(e.lut));
            chk("ev_sb",   424'(SB_in),                424'(e.sb));
            chk("ev_cb",   424'(CB_in),                424'(e.cb));
            chk("ev_dirb", 424'(sel_direction_BLEout), 424'(e.dirb));
            chk("ev_dir",  424'(sel_direction),        424'(e.dir));
            chk("ev_ble",  424'(BLE_dff_select),       424'(e.ble));
            chk("ev_io",   424'(IO_sel),               424'(e.io));
            chk("complete_at_done", 424'(cfg_complete), 424'(e.cmp_now));
            pend_next = 1'b1;
            want_next = e.cmp_next;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    model_clear();
    do_reset();

    // Single-byte IO frame.
    pl[0] = 8'h0F;
    send_frame(8'd6, 1'b0, 1'b0);
    drain();
    chk("io_0f", 424'(IO_sel), 424'(4'hF));
    chk("complete_single", 424'(cfg_complete), 424'(1'b0));
    chk_all("after_io");

    // Good then bad checksum on BLE select.
    pl[0] = 8'h03; pl[1] = 8'h00;
    send_frame(8'd5, 1'b0, 1'b0);
    send_frame(8'd5, 1'b1, 1'b0);
    drain();
    chk("ble_003", 424'(BLE_dff_select), 424'(9'h003));

    // Invalid ID followed by a good frame.
    send_frame(8'd9, 1'b0, 1'b0);
    pl[0] = 8'h0A;
    send_frame(8'd6, 1'b0, 1'b0);
    drain();
    chk("io_0a", 424'(IO_sel), 424'(4'hA));

    // Idle garbage, then a frame carrying the sync value as payload.
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b);
    end
    fill_random(5);
    pl[0] = 8'hA5;
    pl[2] = 8'hA5;
    send_frame(8'd3, 1'b0, 1'b0);
    drain();
    chk_all("sync_in_data");

    // Reset mid-payload of ID 1, then a full ID 1 frame.
    send_byte(8'hA5);
    send_byte(8'd1);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    do_reset();
    chk("sb_after_abort", 424'(SB_in), 424'(240'd0));
    fill_random(30);
    send_frame(8'd1, 1'b0, 1'b0);
    drain();
    chk_all("sb_reload");

    // Reset landing on the commit cycle must suppress the update.
    fill_random(5);
    send_frame(8'd3, 1'b0, 1'b1);
    do_reset();
    chk("dirb_reset_commit", 424'(sel_direction_BLEout), 424'(36'd0));

    // LUT load with random stalls.
    g_stall = 1'b1;
    fill_random(18);
    pl[0] = 8'h96; pl[1] = 8'h96; pl[2] = 8'hE8;
    send_frame(8'd0, 1'b0, 1'b0);
    drain();
    chk_all("lut_stall");

    // All seven targets in order from a clean state.
    do_reset();
    for (int id = 0; id < 7; id++) begin
      fill_random(n_of(8'(id)));
      send_frame(8'(id), 1'b0, 1'b0);
    end
    drain();
    chk("complete_all", 424'(cfg_complete), 424'(1'b1));
    chk_all("all_ids");

    // Randomised mix of good, corrupt and invalid-ID frames.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] rid;
      rid = 8'($urandom_range(0, 8));
      fill_random(n_of(rid));
      send_frame(rid, ($urandom_range(0, 3) == 0), 1'b0);
    end
    drain();
    chk_all("final");
    chk("complete_final", 424'(cfg_complete), 424'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
